// File: rtl/fpu_pkg.sv
// Shared definitions for the adder arbiter: FSM state encoding, the quiet-NaN
// word substituted on a watchdog abort, and the number of requesters.
package fpu_pkg;

  localparam int          NUM_REQ = 2;
  localparam logic [31:0] QNAN    = 32'h7fffffff;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESPOND
  } state_e;

endpackage

// File: rtl/adder_arbiter_if.sv
// Bundle of requester-side and adder-side signals of the adder arbiter.
// Signal suffixes are from the arbiter's point of view; the arbiter takes the
// slave modport, the requesters/adder environment takes the master modport.
interface adder_arbiter_if;
  import fpu_pkg::*;

  logic [NUM_REQ-1:0]    req_valid_i;
  logic [NUM_REQ-1:0]    req_ready_o;
  logic [32*NUM_REQ-1:0] req_x_i;
  logic [32*NUM_REQ-1:0] req_y_i;
  logic [NUM_REQ-1:0]    rsp_valid_o;
  logic [31:0]           rsp_z_o;
  logic                  rsp_invalid_o;
  logic                  rsp_overflow_o;
  logic                  rsp_timeout_o;
  logic                  fu_valid_o;
  logic [31:0]           fu_x_o;
  logic [31:0]           fu_y_o;
  logic                  fu_valid_i;
  logic [31:0]           fu_z_i;
  logic                  fu_invalid_i;
  logic                  fu_overflow_i;

  modport slave (
    input  req_valid_i, req_x_i, req_y_i,
    input  fu_valid_i, fu_z_i, fu_invalid_i, fu_overflow_i,
    output req_ready_o, rsp_valid_o, rsp_z_o,
    output rsp_invalid_o, rsp_overflow_o, rsp_timeout_o,
    output fu_valid_o, fu_x_o, fu_y_o
  );

  modport master (
    output req_valid_i, req_x_i, req_y_i,
    output fu_valid_i, fu_z_i, fu_invalid_i, fu_overflow_i,
    input  req_ready_o, rsp_valid_o, rsp_z_o,
    input  rsp_invalid_o, rsp_overflow_o, rsp_timeout_o,
    input  fu_valid_o, fu_x_o, fu_y_o
  );

endinterface

// File: rtl/adder_arbiter_rr.sv
// Two-way round-robin arbiter. A lone request is granted directly; on a tie
// the requester that did not win last time gets the grant. The last-winner
// register only moves when the caller signals that the grant was taken.
module rr_arbiter
  import fpu_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               update_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  logic last_q, last_d;

  // Grant selection: ties go to the requester that lost the previous round
  always_comb begin
    gnt_o = '0;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
      default: gnt_o = '0;
    endcase
  end

  // Remember the winner only when the grant is actually consumed
  always_comb begin
    last_d = last_q;
    if (update_i && (gnt_o != '0)) begin
      last_d = gnt_o[1];
    end
  end

  // Last-winner register; starts at requester 1 so requester 0 wins the first tie
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one floating-point adder between two requesters, one transaction at a
// time: grant in IDLE, issue for one cycle, wait for the adder, respond for one
// cycle to the owner. Optional watchdog on the wait, enabled by the
// ADDER_ARB_TIMEOUT_EN macro; without it the wait is unbounded.
module adder_arbiter
  import fpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  adder_arbiter_if.slave bus
);

  state_e             state_q, state_d;
  logic               owner_q, owner_d;
  logic [31:0]        x_q, x_d, y_q, y_d, z_q, z_d;
  logic               inv_q, inv_d, ovf_q, ovf_d;
  logic [NUM_REQ-1:0] gnt, req_ready, rsp_valid;
  logic               arb_update, fu_valid;

`ifdef ADDER_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
`endif

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("adder_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  rr_arbiter u_arb (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (bus.req_valid_i),
    .update_i (arb_update),
    .gnt_o    (gnt)
  );

  // Transaction sequencing and the operand/result capture for each phase
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    x_d        = x_q;
    y_d        = y_q;
    z_d        = z_q;
    inv_d      = inv_q;
    ovf_d      = ovf_q;
    arb_update = 1'b0;
    req_ready  = '0;
    fu_valid   = 1'b0;
    rsp_valid  = '0;
`ifdef ADDER_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (gnt != '0) begin
          req_ready  = gnt;
          arb_update = 1'b1;
          owner_d    = gnt[1];
          x_d        = gnt[1] ? bus.req_x_i[63:32] : bus.req_x_i[31:0];
          y_d        = gnt[1] ? bus.req_y_i[63:32] : bus.req_y_i[31:0];
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        fu_valid = 1'b1;
        state_d  = ST_WAIT;
`ifdef ADDER_ARB_TIMEOUT_EN
        cnt_d    = '0;
`endif
      end
      ST_WAIT: begin
        if (bus.fu_valid_i) begin
          z_d     = bus.fu_z_i;
          inv_d   = bus.fu_invalid_i;
          ovf_d   = bus.fu_overflow_i;
          state_d = ST_RESPOND;
`ifdef ADDER_ARB_TIMEOUT_EN
          tmo_d   = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          z_d     = QNAN;
          inv_d   = 1'b1;
          ovf_d   = 1'b0;
          tmo_d   = 1'b1;
          state_d = ST_RESPOND;
        end else begin
          cnt_d   = cnt_q + 1'b1;
`endif
        end
      end
      ST_RESPOND: begin
        rsp_valid[owner_q] = 1'b1;
        state_d            = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      inv_q   <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef ADDER_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      inv_q   <= inv_d;
      ovf_q   <= ovf_d;
`ifdef ADDER_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign bus.req_ready_o    = req_ready;
  assign bus.fu_valid_o     = fu_valid;
  assign bus.fu_x_o         = x_q;
  assign bus.fu_y_o         = y_q;
  assign bus.rsp_valid_o    = rsp_valid;
  assign bus.rsp_z_o        = z_q;
  assign bus.rsp_invalid_o  = inv_q;
  assign bus.rsp_overflow_o = ovf_q;
`ifdef ADDER_ARB_TIMEOUT_EN
  assign bus.rsp_timeout_o  = tmo_q;
`else
  assign bus.rsp_timeout_o  = 1'b0;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter. A transaction-timeline model predicts
// every output each cycle; a responder plays the adder with a chosen latency.
// Define ADDER_ARB_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYCLES=8).
module tb_adder_arbiter;
  import fpu_pkg::*;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adder_arbiter_if bus ();

  adder_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Model state: who is busy, who owns it, when issue/response are due
  bit          mBusy = 0;
  int          mLast = 1;
  int          mOwner = 0;
  logic [31:0] mX = '0, mY = '0, mZ = '0;
  bit          mInv = 0, mOvf = 0, mTmo = 0;
  int          issueAt = -1, respAt = -1;

  // Observation log used by the directed literal checks
  int          grantLog[$];
  int          rspLog[$];
  int          readyCount[2] = '{0, 0};
  int          fuCount = 0, rspCount = 0, issueCycle = 0, rspCycle = 0;
  logic [1:0]  lastRspValid = '0;
  logic [31:0] lastRspZ = '0;
  logic        lastRspInv = 0, lastRspOvf = 0, lastRspTmo = 0;

  // Adder responder controls
  bit          adderSilent = 0, adderRandom = 0;
  int          adderLat = 4;
  bit          pend = 0;
  int          pendAt = 0;
  logic [31:0] pendZ = '0;
  bit          pendInv = 0, pendOvf = 0;
  logic [31:0] zQ[$];
  bit          invQ[$], ovfQ[$];
  int          strayAt = -1;

  logic [1:0]  expReady, expRsp, reqSample;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] grantOf(input logic [1:0] r, input int last);
    if (r == 2'b11) return (last == 1) ? 2'b01 : 2'b10;
    return r;
  endfunction

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] v, input logic [31:0] x0, input logic [31:0] y0,
                               input logic [31:0] x1, input logic [31:0] y1);
    bus.req_valid_i = v;
    bus.req_x_i     = {x1, x0};
    bus.req_y_i     = {y1, y0};
  endtask

  task automatic waitRsp(input int budget, input string name);
    int start;
    start = rspCount;
    for (int i = 0; i < budget && rspCount == start; i++) stepCycle();
    checkOutput(name, 32'(rspCount != start), 32'd1);
  endtask

  task automatic singleTxn(input int idx, input logic [31:0] x, input logic [31:0] y);
    if (idx == 0) applyStimulus(2'b01, x, y, $urandom, $urandom);
    else          applyStimulus(2'b10, $urandom, $urandom, x, y);
    stepCycle();
    applyStimulus(2'b00, $urandom, $urandom, $urandom, $urandom);
    waitRsp(40, "single_rsp_arrived");
  endtask

  // Adder stand-in: accept each issue, answer after the chosen latency
  always @(negedge clk) begin
    if (rst_n && bus.fu_valid_o && !adderSilent) begin
      pend   = 1;
      pendAt = cyc + (adderRandom ? int'($urandom_range(1, 5)) : adderLat);
      if (zQ.size() > 0) begin
        pendZ   = zQ.pop_front();
        pendInv = invQ.pop_front();
        pendOvf = ovfQ.pop_front();
      end else begin
        pendZ   = bus.fu_x_o + bus.fu_y_o;
        pendInv = bus.fu_x_o[0];
        pendOvf = bus.fu_y_o[0];
      end
    end
  end

  // Adder output driver; drives garbage on z/flags whenever not valid
  initial begin
    bus.fu_valid_i    = 0;
    bus.fu_z_i        = '0;
    bus.fu_invalid_i  = 0;
    bus.fu_overflow_i = 0;
    forever begin
      @(posedge clk);
      #1;
      if (pend && cyc == pendAt) begin
        bus.fu_valid_i    = 1;
        bus.fu_z_i        = pendZ;
        bus.fu_invalid_i  = pendInv;
        bus.fu_overflow_i = pendOvf;
        pend              = 0;
      end else if (cyc == strayAt) begin
        bus.fu_valid_i    = 1;
        bus.fu_z_i        = 32'hdeadbeef;
        bus.fu_invalid_i  = 1;
        bus.fu_overflow_i = 1;
      end else begin
        bus.fu_valid_i    = 0;
        bus.fu_z_i        = $urandom;
        bus.fu_invalid_i  = $urandom_range(0, 1);
        bus.fu_overflow_i = $urandom_range(0, 1);
      end
    end
  end

  // Compare every output against the model, then advance the model one cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      mBusy = 0; mLast = 1; mOwner = 0; mX = '0; mY = '0; mZ = '0;
      mInv = 0; mOvf = 0; mTmo = 0; issueAt = -1; respAt = -1;
      checkOutput("reset_req_ready", 32'(bus.req_ready_o), 32'd0);
      checkOutput("reset_fu_valid", 32'(bus.fu_valid_o), 32'd0);
      checkOutput("reset_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
      checkOutput("reset_rsp_z", bus.rsp_z_o, 32'd0);
      checkOutput("reset_fu_x", bus.fu_x_o, 32'd0);
    end else begin
      reqSample = bus.req_valid_i;
      expReady  = mBusy ? 2'b00 : grantOf(reqSample, mLast);
      expRsp    = (mBusy && cyc == respAt) ? (2'b01 << mOwner) : 2'b00;
      checkOutput("req_ready", 32'(bus.req_ready_o), 32'(expReady));
      checkOutput("fu_valid", 32'(bus.fu_valid_o), 32'(mBusy && cyc == issueAt));
      if (mBusy && issueAt >= 0 && cyc >= issueAt && respAt < 0) begin
        checkOutput("fu_x", bus.fu_x_o, mX);
        checkOutput("fu_y", bus.fu_y_o, mY);
      end
      checkOutput("rsp_valid", 32'(bus.rsp_valid_o), 32'(expRsp));
      checkOutput("rsp_z", bus.rsp_z_o, mZ);
      checkOutput("rsp_invalid", 32'(bus.rsp_invalid_o), 32'(mInv));
      checkOutput("rsp_overflow", 32'(bus.rsp_overflow_o), 32'(mOvf));
      checkOutput("rsp_timeout", 32'(bus.rsp_timeout_o), 32'(mTmo));

      if (bus.req_ready_o != 2'b00) begin
        grantLog.push_back(int'(bus.req_ready_o[1]));
        readyCount[bus.req_ready_o[1]]++;
      end
      if (bus.fu_valid_o) begin
        fuCount++;
        issueCycle = cyc;
      end
      if (bus.rsp_valid_o != 2'b00) begin
        rspCount++;
        rspCycle     = cyc;
        lastRspValid = bus.rsp_valid_o;
        lastRspZ     = bus.rsp_z_o;
        lastRspInv   = bus.rsp_invalid_o;
        lastRspOvf   = bus.rsp_overflow_o;
        lastRspTmo   = bus.rsp_timeout_o;
        rspLog.push_back(int'(bus.rsp_valid_o));
      end

      if (mBusy && cyc == respAt) begin
        mBusy = 0; issueAt = -1; respAt = -1;
      end else if (!mBusy) begin
        if (expReady != 2'b00) begin
          mBusy   = 1;
          mOwner  = int'(expReady[1]);
          mLast   = mOwner;
          mX      = expReady[1] ? bus.req_x_i[63:32] : bus.req_x_i[31:0];
          mY      = expReady[1] ? bus.req_y_i[63:32] : bus.req_y_i[31:0];
          issueAt = cyc + 1;
          respAt  = -1;
        end
      end else if (respAt < 0 && cyc > issueAt) begin
        if (bus.fu_valid_i) begin
          respAt = cyc + 1;
          mZ = bus.fu_z_i; mInv = bus.fu_invalid_i; mOvf = bus.fu_overflow_i; mTmo = 0;
        end
`ifdef ADDER_ARB_TIMEOUT_EN
        else if (cyc - issueAt == TO) begin
          respAt = cyc + 1;
          mZ = 32'h7fffffff; mInv = 1; mOvf = 0; mTmo = 1;
        end
`endif
      end
    end
  end

  initial begin
    int n, f, r0;
    applyStimulus(2'b00, '0, '0, '0, '0);
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_timeout_flag", 32'(bus.rsp_timeout_o), 32'd0);
    rst_n = 1;

    // Single request from requester 0, adder answers 1.0+2.0=3.0 after 4 cycles
    $display("[TB] single transaction");
    zQ.push_back(32'h40400000); invQ.push_back(0); ovfQ.push_back(0);
    adderLat = 4;
    r0 = readyCount[0]; f = fuCount;
    singleTxn(0, 32'h3f800000, 32'h40000000);
    checkOutput("single_ready0_pulses", 32'(readyCount[0] - r0), 32'd1);
    checkOutput("single_fu_pulses", 32'(fuCount - f), 32'd1);
    checkOutput("single_rsp_valid", 32'(lastRspValid), 32'h1);
    checkOutput("single_rsp_z", lastRspZ, 32'h40400000);
    checkOutput("single_issue_to_rsp", 32'(rspCycle - issueCycle), 32'd5);

    // Requester 1 alone, so the next tie goes to requester 0
    singleTxn(1, $urandom, $urandom);

    // Contention: both held valid for four transactions
    $display("[TB] contention");
    grantLog.delete(); rspLog.delete();
    applyStimulus(2'b11, $urandom, $urandom, $urandom, $urandom);
    for (int i = 0; i < 4; i++) waitRsp(40, "contention_rsp_arrived");
    applyStimulus(2'b00, $urandom, $urandom, $urandom, $urandom);
    checkOutput("contention_grants", 32'(grantLog.size()), 32'd4);
    for (int i = 0; i < 4 && i < grantLog.size(); i++)
      checkOutput("contention_order", 32'(grantLog[i]), 32'(i % 2));
    for (int i = 0; i < 4 && i < rspLog.size(); i++)
      checkOutput("contention_rsp_owner", 32'(rspLog[i]), (i % 2 == 0) ? 32'h1 : 32'h2);

    // Exception flags pass through and are replaced by the next response
    $display("[TB] flags");
    zQ.push_back(32'h7fffffff); invQ.push_back(1); ovfQ.push_back(0);
    singleTxn(0, $urandom, $urandom);
    checkOutput("flags_invalid", 32'(lastRspInv), 32'd1);
    checkOutput("flags_invalid_z", lastRspZ, 32'h7fffffff);
    zQ.push_back(32'h7f800000); invQ.push_back(0); ovfQ.push_back(1);
    singleTxn(1, $urandom, $urandom);
    checkOutput("flags_overflow", 32'(lastRspOvf), 32'd1);
    checkOutput("flags_overflow_inv", 32'(lastRspInv), 32'd0);
    checkOutput("flags_overflow_z", lastRspZ, 32'h7f800000);

    // Stray adder completion while idle
    $display("[TB] stray completion in idle");
    n = rspCount; f = fuCount;
    strayAt = cyc + 2;
    repeat (5) stepCycle();
    checkOutput("stray_no_rsp", 32'(rspCount - n), 32'd0);
    checkOutput("stray_no_issue", 32'(fuCount - f), 32'd0);

    // Reset while waiting on the adder; its late answer must be dropped
    $display("[TB] reset during wait");
    adderLat = 6;
    n = rspCount; f = fuCount;
    applyStimulus(2'b10, $urandom, $urandom, $urandom, $urandom);
    stepCycle();
    applyStimulus(2'b00, $urandom, $urandom, $urandom, $urandom);
    stepCycle();
    stepCycle();
    checkOutput("rstwait_in_flight", 32'(fuCount - f), 32'd1);
    #2 rst_n = 0;
    stepCycle();
    stepCycle();
    rst_n = 1;
    repeat (10) stepCycle();
    checkOutput("rstwait_no_rsp", 32'(rspCount - n), 32'd0);
    grantLog.delete();
    applyStimulus(2'b11, $urandom, $urandom, $urandom, $urandom);
    stepCycle();
    applyStimulus(2'b00, $urandom, $urandom, $urandom, $urandom);
    checkOutput("rstwait_grants", 32'(grantLog.size()), 32'd1);
    if (grantLog.size() > 0) checkOutput("rstwait_first_grant", 32'(grantLog[0]), 32'd0);
    waitRsp(40, "rstwait_rsp_arrived");

    // Randomized requests, withdrawals and adder latencies
    $display("[TB] random traffic");
    adderRandom = 1;
    adderLat = 4;
    n = rspCount;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom);
      stepCycle();
    end
    applyStimulus(2'b00, $urandom, $urandom, $urandom, $urandom);
    for (int i = 0; i < 40 && mBusy; i++) stepCycle();
    checkOutput("random_drained", 32'(mBusy), 32'd0);
    checkOutput("random_progress", 32'(rspCount > n), 32'd1);
    adderRandom = 0;
    stepCycle();

`ifdef ADDER_ARB_TIMEOUT_EN
    // Silent adder: the watchdog answers after TO wait cycles
    $display("[TB] watchdog");
    adderSilent = 1;
    singleTxn(0, $urandom, $urandom);
    checkOutput("timeout_latency", 32'(rspCycle - issueCycle), 32'(TO + 1));
    checkOutput("timeout_z", lastRspZ, 32'h7fffffff);
    checkOutput("timeout_invalid", 32'(lastRspInv), 32'd1);
    checkOutput("timeout_overflow", 32'(lastRspOvf), 32'd0);
    checkOutput("timeout_flag", 32'(lastRspTmo), 32'd1);
    adderSilent = 0;
    singleTxn(1, $urandom, $urandom);
    checkOutput("timeout_flag_cleared", 32'(lastRspTmo), 32'd0);
`endif

    stepCycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
